kong_intro_ctl: RTL



---
 rtl/kong_intro_ctl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/kong_intro_ctl.sv
// Kong intro animation position controller: climb, hop, walk to the platform slot.
// Optional idle hopping in DONE is enabled by defining KONG_IDLE_HOP_EN.
module kong_intro_ctl #(
  parameter int START_X     = 484,
  parameter int START_Y     = 672,
  parameter int PLATFORM_X  = 128,
  parameter int PLATFORM_Y  = 175,
  parameter int JUMP_HEIGHT = 58,
  parameter int MOVE_TICKS  = 250_000,
  parameter int JUMP_TICKS  = 1_400_000,
  parameter int HOP_PERIOD  = 2_800_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        busy,
  output logic        airborne,
  output logic        done
);

  localparam int CNT_MAX0 = (MOVE_TICKS > JUMP_TICKS) ? MOVE_TICKS : JUMP_TICKS;
  localparam int CNT_MAX  = (CNT_MAX0 > HOP_PERIOD) ? CNT_MAX0 : HOP_PERIOD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int APEX_I   = (PLATFORM_Y > JUMP_HEIGHT) ? (PLATFORM_Y - JUMP_HEIGHT) : 0;

  localparam logic [10:0] SX   = 11'(START_X);
  localparam logic [10:0] SY   = 11'(START_Y);
  localparam logic [10:0] PX   = 11'(PLATFORM_X);
  localparam logic [10:0] PY   = 11'(PLATFORM_Y);
  localparam logic [10:0] APEX = 11'(APEX_I);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0] JUMP_LAST = CNT_W'(JUMP_TICKS - 1);
`ifdef KONG_IDLE_HOP_EN
  localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP_PERIOD - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CLIMB, S_HOP_UP, S_HOP_HOLD, S_HOP_DOWN, S_WALK, S_DONE
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_last_s;
  logic [10:0]      xpos_r, ypos_r, xpos_s, ypos_s;
  logic             idle_hop_r, idle_hop_s;
  logic             busy_r, airborne_r, done_r;
  logic             busy_s, airborne_s, done_s;
  logic             step_s, cnt_hold_s;

  assign xpos     = xpos_r;
  assign ypos     = ypos_r;
  assign busy     = busy_r;
  assign airborne = airborne_r;
  assign done     = done_r;

  // Per-state tick period and step strobe
  always_comb begin
    cnt_last_s = MOVE_LAST;
    cnt_hold_s = 1'b0;
    case (state_r)
      S_HOP_HOLD: cnt_last_s = JUMP_LAST;
      S_IDLE:     cnt_hold_s = 1'b1;
`ifdef KONG_IDLE_HOP_EN
      S_DONE:     cnt_last_s = HOP_LAST;
`else
      S_DONE:     cnt_hold_s = 1'b1;
`endif
      default:    cnt_last_s = MOVE_LAST;
    endcase
    step_s = (cnt_r == cnt_last_s);
  end

  // Next-state, next-position and next-output logic
  always_comb begin
    state_s    = state_r;
    xpos_s     = xpos_r;
    ypos_s     = ypos_r;
    idle_hop_s = idle_hop_r;
    if (abort) begin
      state_s    = S_IDLE;
      xpos_s     = SX;
      ypos_s     = SY;
      idle_hop_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) state_s = (PLATFORM_Y >= START_Y) ? S_HOP_UP : S_CLIMB;
          else       state_s = S_IDLE;
        end
        S_CLIMB: begin
          if (ypos_r <= PY) begin
            state_s = S_HOP_UP;
          end else if (step_s) begin
            ypos_s = ypos_r - 11'd1;
            if (ypos_r - 11'd1 == PY) state_s = S_HOP_UP;
            else                      state_s = S_CLIMB;
          end else begin
            state_s = S_CLIMB;
          end
        end
        // Rise stops at the clamped apex so a tall hop never wraps below row 0
        S_HOP_UP: begin
          if (ypos_r <= APEX) begin
            state_s = S_HOP_HOLD;
          end else if (step_s) begin
            ypos_s = ypos_r - 11'd1;
            if (ypos_r - 11'd1 == APEX) state_s = S_HOP_HOLD;
            else                        state_s = S_HOP_UP;
          end else begin
            state_s = S_HOP_UP;
          end
        end
        S_HOP_HOLD: begin
          if (step_s) state_s = S_HOP_DOWN;
          else        state_s = S_HOP_HOLD;
        end
        S_HOP_DOWN: begin
          if (ypos_r >= PY || (step_s && (ypos_r + 11'd1 == PY))) begin
            state_s    = idle_hop_r ? S_DONE : S_WALK;
            idle_hop_s = 1'b0;
          end else begin
            state_s = S_HOP_DOWN;
          end
          if (ypos_r < PY && step_s) ypos_s = ypos_r + 11'd1;
          else                       ypos_s = ypos_r;
        end
        S_WALK: begin
          if (xpos_r <= PX) begin
            state_s = S_DONE;
          end else if (step_s) begin
            xpos_s = xpos_r - 11'd1;
            if (xpos_r - 11'd1 == PX) state_s = S_DONE;
            else                      state_s = S_WALK;
          end else begin
            state_s = S_WALK;
          end
        end
        S_DONE: begin
`ifdef KONG_IDLE_HOP_EN
          if (step_s) begin
            state_s    = S_HOP_UP;
            idle_hop_s = 1'b1;
          end else begin
            state_s = S_DONE;
          end
`else
          state_s = S_DONE;
`endif
        end
        default: state_s = S_IDLE;
      endcase
    end

    if (abort || (state_s != state_r) || step_s || cnt_hold_s) cnt_s = {CNT_W{1'b0}};
    else                                                        cnt_s = cnt_r + CNT_W'(1);

    busy_s     = !((state_s == S_IDLE) || (state_s == S_DONE) || idle_hop_s);
    airborne_s = (state_s == S_HOP_UP) || (state_s == S_HOP_HOLD) || (state_s == S_HOP_DOWN);
    done_s     = (state_s == S_DONE) || idle_hop_s;
  end

  // State, counter, position and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      xpos_r     <= SX;
      ypos_r     <= SY;
      idle_hop_r <= 1'b0;
      busy_r     <= 1'b0;
      airborne_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      xpos_r     <= xpos_s;
      ypos_r     <= ypos_s;
      idle_hop_r <= idle_hop_s;
      busy_r     <= busy_s;
      airborne_r <= airborne_s;
      done_r     <= done_s;
    end
  end

endmodule
